uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_ff.sv | 24 ++
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types and defaults
package uart_pkg;

  // 100 MHz clock at 38400 baud
  localparam int CLKS_PER_BIT_DEFAULT = 2604;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - N-stage flop synchronizer for an asynchronous single-bit input
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, mid-bit sampling, framing-error recovery
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frame_err,
  output logic       busy
);

  localparam int               SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             rdy_q, rdy_d;
  logic             ferr_q, ferr_d;

  sync_ff #(
    .STAGES    (SYNC_N),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    rdy_d     = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end

      // A start bit that is high again at its midpoint is treated as a glitch
      ST_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge
      ST_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            rdy_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_rdy    = rdy_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at full and reduced bit rates
module tb_uart_rx;

  localparam int CPB_SLOW = 2604;
  localparam int CPB_FAST = 16;
  localparam int SYNC_N   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_drv;
  logic       use_slow;
  logic       rx_s, rx_f;
  logic [7:0] data_s, data_f;
  logic       rdy_s, rdy_f, ferr_s, ferr_f, busy_s, busy_f;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         n_rdy = 0;
  int         n_ferr = 0;
  int         cyc = 0;
  int         rdy_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] prev_s, prev_f;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rx_s = use_slow ? rx_drv : 1'b1;
  assign rx_f = use_slow ? 1'b1 : rx_drv;

  uart_rx #(.CLKS_PER_BIT(CPB_SLOW), .SYNC_STAGES(SYNC_N)) dut_slow (
    .clk(clk), .rst(rst), .rx(rx_s),
    .rx_data(data_s), .rx_rdy(rdy_s), .frame_err(ferr_s), .busy(busy_s)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_FAST), .SYNC_STAGES(SYNC_N)) dut_fast (
    .clk(clk), .rst(rst), .rx(rx_f),
    .rx_data(data_f), .rx_rdy(rdy_f), .frame_err(ferr_f), .busy(busy_f)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sb_pop(input logic [7:0] got);
    if (exp_q.size() == 0) check_eq("sb_unexpected_rdy", 32'd1, 32'd0);
    else check_eq("rx_data", {24'd0, got}, {24'd0, exp_q.pop_front()});
  endtask

  always @(negedge clk) begin
    if (rdy_s) sb_pop(data_s);
    if (rdy_f) sb_pop(data_f);
    if (rdy_s || rdy_f) begin
      n_rdy++;
      rdy_cyc = cyc;
    end
    if (ferr_s || ferr_f) n_ferr++;
    if (rdy_s || ferr_s) check_eq("rdy_ferr_excl_s", {31'd0, rdy_s & ferr_s}, 32'd0);
    if (rdy_f || ferr_f) check_eq("rdy_ferr_excl_f", {31'd0, rdy_f & ferr_f}, 32'd0);
    if (!rst && data_s !== prev_s && !rdy_s) check_eq("data_hold_s", {24'd0, data_s}, {24'd0, prev_s});
    if (!rst && data_f !== prev_f && !rdy_f) check_eq("data_hold_f", {24'd0, data_f}, {24'd0, prev_f});
    prev_s = data_s;
    prev_f = data_f;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int cpb);
    rx_drv = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (cpb) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (cpb) @(negedge clk);
  endtask

  initial begin
    int c0, lat, base_rdy, base_ferr;
    rst = 1'b1;
    rx_drv = 1'b1;
    use_slow = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_data_s", {24'd0, data_s}, 32'h0);
    check_eq("reset_data_f", {24'd0, data_f}, 32'h0);
    check_eq("reset_busy", {30'd0, busy_s, busy_f}, 32'd0);
    check_eq("reset_pulses", {28'd0, rdy_s, rdy_f, ferr_s, ferr_f}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 0x55 at full bit period, with latency measured from the synchronized edge
    exp_q.push_back(8'h55);
    c0 = cyc;
    send_byte(8'h55, 1'b1, CPB_SLOW);
    lat = rdy_cyc - c0 - SYNC_N;
    check_eq("latency_in_window",
             {31'd0, (lat >= (CPB_SLOW * 19) / 2) && (lat <= (CPB_SLOW * 19) / 2 + 2)}, 32'd1);
    check_eq("rdy_count_55", n_rdy, 1);

    // Start-bit glitch shorter than half a bit
    base_rdy = n_rdy;
    base_ferr = n_ferr;
    rx_drv = 1'b0;
    repeat (500) @(negedge clk);
    check_eq("glitch_busy_mid", {31'd0, busy_s}, 32'd1);
    repeat (500) @(negedge clk);
    rx_drv = 1'b1;
    repeat (1000) @(negedge clk);
    check_eq("glitch_busy_end", {31'd0, busy_s}, 32'd0);
    check_eq("glitch_no_rdy", n_rdy, base_rdy);
    check_eq("glitch_no_ferr", n_ferr, base_ferr);

    use_slow = 1'b0;
    repeat (4) @(negedge clk);

    // Back-to-back frames
    base_rdy = n_rdy;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, CPB_FAST);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, CPB_FAST);
    repeat (4) @(negedge clk);
    check_eq("b2b_rdy_count", n_rdy, base_rdy + 2);
    check_eq("b2b_no_ferr", n_ferr, base_ferr);

    // Framing error followed by a held-low line
    base_rdy = n_rdy;
    send_byte(8'h81, 1'b0, CPB_FAST);
    repeat (3 * CPB_FAST) @(negedge clk);
    check_eq("ferr_count", n_ferr, base_ferr + 1);
    check_eq("ferr_data_kept", {24'd0, data_f}, 32'h3C);
    check_eq("ferr_wait_busy", {31'd0, busy_f}, 32'd1);
    check_eq("ferr_no_rdy", n_rdy, base_rdy);
    rx_drv = 1'b1;
    repeat (2 * CPB_FAST) @(negedge clk);
    check_eq("ferr_idle_again", {31'd0, busy_f}, 32'd0);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1, CPB_FAST);
    check_eq("after_ferr_rdy", n_rdy, base_rdy + 1);

    // Reset in the middle of bit 4 of 0xF0
    base_rdy = n_rdy;
    base_ferr = n_ferr;
    rx_drv = 1'b0;
    repeat (CPB_FAST) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_drv = 1'b0;
      repeat (CPB_FAST) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (CPB_FAST / 2) @(negedge clk);
    check_eq("midframe_busy", {31'd0, busy_f}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_data", {24'd0, data_f}, 32'h0);
    check_eq("midrst_busy", {31'd0, busy_f}, 32'd0);
    check_eq("midrst_pulses", {30'd0, rdy_f, ferr_f}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("midrst_no_rdy", n_rdy, base_rdy);
    check_eq("midrst_no_ferr", n_ferr, base_ferr);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1, CPB_FAST);
    check_eq("after_rst_data", {24'd0, data_f}, 32'h0F);

    // Long back-to-back stream
    base_rdy = n_rdy;
    base_ferr = n_ferr;
    for (int i = 0; i < 98; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, CPB_FAST);
    end
    repeat (4) @(negedge clk);
    check_eq("stream_rdy_count", n_rdy, base_rdy + 98);
    check_eq("stream_no_ferr", n_ferr, base_ferr);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
